vga_bounce_box_control: RTL
===========================

// Module: vga_bounce_box_control
// PURPOSE
//  Pixel-colour stage that sits directly downstream of the VGA sync/timing block.
//  Consumes its active-area flag and x/y pixel addresses; drives registered 1-bit R/G/B.
//  Draws a screen frame border and a square box that moves a fixed step once per frame,
//  bouncing off the active-area edges. The position update is confined to blanking so
//  the image does not tear.
// PARAMETERS
//  H_ACT     800  active columns (x range 0..H_ACT-1)
//  V_ACT     600  active rows    (y range 0..V_ACT-1)
//  BOX_SIZE  64   box width = height, pixels
//  SPEED     2    pixels moved per frame on each axis (1..BOX_SIZE)
//  BORDER    4    thickness of the red screen-edge frame, pixels
// PORTS
//  CLK              in   1   pixel clock, rising edge
//  RST              in   1   asynchronous, active-high reset
//  Ready_Sig        in   1   high while the current pixel is in the active area
//  Column_Addr_Sig  in   11  x of current pixel; valid only when Ready_Sig=1
//  Row_Addr_Sig     in   11  y of current pixel; valid only when Ready_Sig=1
//  Red_Sig          out  1   red pixel output, registered
//  Green_Sig        out  1   green pixel output, registered
//  Blue_Sig         out  1   blue pixel output, registered
//  Frame_Done_Sig   out  1   1-cycle pulse after the last active pixel of a frame
// BEHAVIOUR
//  Reset: R/G/B=0, Frame_Done_Sig=0, box_x=box_y=0, dir_x=dir_y=+, FSM=WAIT.
//   Reset applies immediately, also mid-frame; outputs drop the same instant.
//  Frame end: frame_end = Ready_Sig & (Column=H_ACT-1) & (Row=V_ACT-1).
//   Frame_Done_Sig is the registered version of frame_end (1-cycle pulse, next cycle).
//  Pixel colour: 1-cycle latency; the output at cycle t+1 reflects the inputs at cycle t.
//   Priority, highest first:
//   - Ready_Sig=0                                        -> 000
//   - x<BORDER | x>=H_ACT-BORDER | y<BORDER | y>=V_ACT-BORDER -> 100 (red)
//   - box_x<=x<box_x+BOX_SIZE & box_y<=y<box_y+BOX_SIZE  -> 010 (green)
//   - otherwise                                          -> 001 (blue)
//   - Edges: a box pixel that falls inside the border region is drawn red.
//  FSM (3 states):
//   - WAIT: entered at reset. Draws the box at the reset position.
//     On frame_end -> DRAW; position is not updated.
//   - DRAW: normal drawing. On frame_end -> UPD.
//   - UPD: for exactly one cycle, box_x/box_y take their next values; then -> DRAW.
//   - Result: the first move happens at the end of frame 2. The position is constant
//     throughout every active frame.
//  Axis update (identical for x with limit L=H_ACT-BOX_SIZE, and y with L=V_ACT-BOX_SIZE):
//   - dir +: if pos+SPEED >= L then pos<=L, dir<=-; else pos<=pos+SPEED.
//   - dir -: if pos <= SPEED then pos<=0, dir<=+; else pos<=pos-SPEED.
//   - Clamping at L or 0 and reversing direction happen in the same update.
//     pos never leaves 0..L.
//   - All arithmetic is 11-bit unsigned. Compare pos against L-SPEED and SPEED,
//     never against a negative intermediate.
//   - The x and y axes update independently in the same UPD cycle; a corner hit
//     reverses both.
//  Input addresses are ignored while Ready_Sig=0; no assumption is made about their value.
// STRUCTURE
//  Shared header vga_defines.vh: H_ACT/V_ACT defaults, colour codes
//   (COL_BLACK/RED/GREEN/BLUE), FSM state encodings (WAIT=0, DRAW=1, UPD=2).
//  One sub-module, bounce_axis (params LIMIT, SPEED; in CLK, RST, step;
//   out pos[10:0], dir). Instantiated twice, for x and y; step = (FSM==UPD).
//  Top level: frame_end detect, FSM, box/border compare, output register.
// TESTING
//  - Reset mid-frame (RST high while Ready_Sig=1, colour=100) -> RGB=000 and
//    Frame_Done_Sig=0 immediately; box at (0,0) after release.
//  - Frame 1, pixel (100,100) -> blue; pixel (10,10) -> green; pixel (2,300) -> red;
//    Ready_Sig=0 -> 000. Each appears one cycle after the input.
//  - Three full 800x600 frames -> Frame_Done_Sig pulses 3 times, 1 cycle wide each;
//    box_x=0 after frame 1 (WAIT), 2 after frame 2, 4 after frame 3.
//  - Force box_x=735, dir_x=+ -> after UPD box_x=736 (L), dir_x=-;
//    next UPD box_x=734.
//  - Force box_x=box_y=1, dir -,- (corner) -> after UPD box_x=box_y=0, both dirs +.
//  - Long run of 2000 frames -> 0<=box_x<=736 and 0<=box_y<=536 every frame;
//    the position never changes while Ready_Sig=1.

Source files
------------

// File: rtl/vga_bounce_box_control_pkg.sv
// Shared constants and types for the bouncing-box pixel-colour stage.
// Holds screen geometry, box motion parameters, colour codes and FSM states.
package vga_bounce_box_control_pkg;

  localparam int unsigned ADDR_W   = 11;
  localparam int unsigned H_ACT    = 800;
  localparam int unsigned V_ACT    = 600;
  localparam int unsigned BOX_SIZE = 64;
  localparam int unsigned SPEED    = 2;
  localparam int unsigned BORDER   = 4;
  localparam int unsigned X_LIMIT  = H_ACT - BOX_SIZE;
  localparam int unsigned Y_LIMIT  = V_ACT - BOX_SIZE;

  typedef logic [ADDR_W-1:0] addr_t;

  // One bit per colour channel, ordered R,G,B
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam rgb_t COL_BLACK = rgb_t'(3'b000);
  localparam rgb_t COL_RED   = rgb_t'(3'b100);
  localparam rgb_t COL_GREEN = rgb_t'(3'b010);
  localparam rgb_t COL_BLUE  = rgb_t'(3'b001);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_DRAW = 2'd1,
    ST_UPD  = 2'd2
  } state_e;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/vga_bounce_box_control_if.sv
// Pixel bus between the VGA timing block and the colour stage.
//  master: timing side, drives active flag and pixel address, receives colour.
//  slave : colour stage, receives address, drives registered RGB and frame pulse.
interface vga_bounce_box_control_if;
  import vga_bounce_box_control_pkg::*;

  logic  Ready_Sig;
  addr_t Column_Addr_Sig;
  addr_t Row_Addr_Sig;
  logic  Red_Sig;
  logic  Green_Sig;
  logic  Blue_Sig;
  logic  Frame_Done_Sig;

  modport master (
    output Ready_Sig, Column_Addr_Sig, Row_Addr_Sig,
    input  Red_Sig, Green_Sig, Blue_Sig, Frame_Done_Sig
  );

  modport slave (
    input  Ready_Sig, Column_Addr_Sig, Row_Addr_Sig,
    output Red_Sig, Green_Sig, Blue_Sig, Frame_Done_Sig
  );
endinterface

// File: rtl/vga_bounce_box_control_axis.sv
// One axis of box motion: position bounces between 0 and LIMIT by SPEED per step.
//  CLK/RST : clock, async active-high reset (pos=0, dir=+)
//  step    : advance one position update this cycle
//  pos     : current position, always within 0..LIMIT
//  dir     : current direction (0 = +, 1 = -)
module bounce_axis
  import vga_bounce_box_control_pkg::*;
#(
  parameter int unsigned LIMIT = 736,
  parameter int unsigned SPEED = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              step,
  output logic [ADDR_W-1:0] pos,
  output logic              dir
);

  // Thresholds are precomputed so no compare ever sees a negative intermediate
  localparam logic [ADDR_W-1:0] LIM     = ADDR_W'(LIMIT);
  localparam logic [ADDR_W-1:0] SPD     = ADDR_W'(SPEED);
  localparam logic [ADDR_W-1:0] LIM_SPD = ADDR_W'(LIMIT - SPEED);

  logic [ADDR_W-1:0] pos_q, pos_d;
  logic              dir_q, dir_d;

  // Next position: clamp and reverse in the same update
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (step) begin
      if (dir_q == DIR_POS) begin
        if (pos_q >= LIM_SPD) begin
          pos_d = LIM;
          dir_d = DIR_NEG;
        end else begin
          pos_d = pos_q + SPD;
        end
      end else begin
        if (pos_q <= SPD) begin
          pos_d = '0;
          dir_d = DIR_POS;
        end else begin
          pos_d = pos_q - SPD;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pos_q <= '0;
      dir_q <= DIR_POS;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;
  assign dir = dir_q;

endmodule

// File: rtl/vga_bounce_box_control.sv
// Pixel-colour stage: red frame border, green bouncing box, blue background.
//  CLK/RST : pixel clock, async active-high reset
//  vga     : slave side of the pixel bus (active flag + x/y in; registered RGB
//            and a one-cycle frame-done pulse out)
// The box moves once per frame, only in the cycle after the last active pixel.
module vga_bounce_box_control
  import vga_bounce_box_control_pkg::*;
(
  input  logic                           CLK,
  input  logic                           RST,
  vga_bounce_box_control_if.slave        vga
);

  state_e state_q, state_d;
  rgb_t   colour_q, colour_d;
  logic   frame_done_q;
  logic   frame_end_c, step_c, in_border_c, in_box_c;
  addr_t  box_x, box_y;
  logic   dir_x, dir_y;
  logic   unused_dir_c;

  assign frame_end_c = vga.Ready_Sig
                     && (vga.Column_Addr_Sig == ADDR_W'(H_ACT - 1))
                     && (vga.Row_Addr_Sig    == ADDR_W'(V_ACT - 1));

  // Box motion, one instance per axis
  bounce_axis #(.LIMIT(X_LIMIT), .SPEED(SPEED)) u_axis_x (
    .CLK (CLK), .RST (RST), .step (step_c), .pos (box_x), .dir (dir_x)
  );

  bounce_axis #(.LIMIT(Y_LIMIT), .SPEED(SPEED)) u_axis_y (
    .CLK (CLK), .RST (RST), .step (step_c), .pos (box_y), .dir (dir_y)
  );

  // Directions only matter inside the axis blocks
  assign unused_dir_c = dir_x ^ dir_y;

  // WAIT skips the first frame end so the first move lands at the end of frame 2
  always_comb begin
    state_d = state_q;
    step_c  = 1'b0;
    case (state_q)
      ST_WAIT: if (frame_end_c) state_d = ST_DRAW;
      ST_DRAW: if (frame_end_c) state_d = ST_UPD;
      ST_UPD: begin
        step_c  = 1'b1;
        state_d = ST_DRAW;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Region decode; box + size reaches at most 800/600, which fits 11 bits
  assign in_border_c = (vga.Column_Addr_Sig <  ADDR_W'(BORDER))
                    || (vga.Column_Addr_Sig >= ADDR_W'(H_ACT - BORDER))
                    || (vga.Row_Addr_Sig    <  ADDR_W'(BORDER))
                    || (vga.Row_Addr_Sig    >= ADDR_W'(V_ACT - BORDER));

  assign in_box_c = (vga.Column_Addr_Sig >= box_x)
                 && (vga.Column_Addr_Sig <  box_x + ADDR_W'(BOX_SIZE))
                 && (vga.Row_Addr_Sig    >= box_y)
                 && (vga.Row_Addr_Sig    <  box_y + ADDR_W'(BOX_SIZE));

  // Colour priority: blank, border, box, background
  always_comb begin
    colour_d = COL_BLUE;
    if (!vga.Ready_Sig)    colour_d = COL_BLACK;
    else if (in_border_c)  colour_d = COL_RED;
    else if (in_box_c)     colour_d = COL_GREEN;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_WAIT;
      colour_q     <= COL_BLACK;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      colour_q     <= colour_d;
      frame_done_q <= frame_end_c;
    end
  end

  assign vga.Red_Sig        = colour_q.r;
  assign vga.Green_Sig      = colour_q.g;
  assign vga.Blue_Sig       = colour_q.b;
  assign vga.Frame_Done_Sig = frame_done_q;

endmodule
